// File: rtl/gpr_read_arbiter_pkg.sv
// Shared types and sizing helpers for the GPR rs3 read-port arbiter.
package gpr_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TC_GRANT = 2'd1,
    COOLDOWN = 2'd2
  } gpr_arb_state_t;

  localparam int GPR_ARB_MAX_WAIT = 8;
  localparam int PERF_CTR_BITS    = 16;

  function automatic int gpr_arb_wait_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

  localparam int GPR_ARB_WAIT_W = gpr_arb_wait_w(GPR_ARB_MAX_WAIT);

endpackage

// File: rtl/gpr_arb_rsp_pipe.sv
// Fixed-depth shift pipe carrying {valid, tag} alongside the GPR RAM read latency.
module gpr_arb_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/gpr_read_arbiter.sv
// rs3 read-port arbiter between in-order issue and tensor-core reads, one per issue slot.
// Optional perf counters enabled with GPR_ARB_PERF_EN.
//   state    | meaning
//   IDLE     | issue has priority until a TC request has waited MAX_WAIT cycles
//   TC_GRANT | TC burst in progress, TC wins every cycle it requests
//   COOLDOWN | one slot reserved for issue after a full burst
module gpr_read_arbiter
  import gpr_read_arbiter_pkg::*;
#(
  parameter int ADDRW      = 5,
  parameter int TAGW       = 4,
  parameter int MAX_WAIT   = GPR_ARB_MAX_WAIT,
  parameter int BURST_MAX  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic             iss_space,
  output logic             iss_ready,
  input  logic             tc_req_valid,
  input  logic [ADDRW-1:0] tc_req_addr,
  input  logic [TAGW-1:0]  tc_req_tag,
  output logic             tc_req_ready,
  output logic             tc_rsp_valid,
  output logic [TAGW-1:0]  tc_rsp_tag,
  output logic             port_sel_tc,
  output logic [ADDRW-1:0] port_tc_addr,
  output logic             port_read_en
`ifdef GPR_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_tc_stall_cycles,
  output logic [PERF_CTR_BITS-1:0] perf_iss_stall_cycles,
  output logic [PERF_CTR_BITS-1:0] perf_forced_grants
`endif
);

  localparam int WAIT_W = gpr_arb_wait_w(MAX_WAIT);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

  gpr_arb_state_t    state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic              wait_full;
  logic              tc_grant;
  logic              iss_fire;
  logic [TAGW:0]     rsp_word;

  assign wait_full = (wait_cnt == WAIT_MAX);
  assign tc_grant  = tc_req_ready;
  assign iss_fire  = iss_valid & iss_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // iss_ready never looks at iss_valid, so there is no valid->ready comb path.
  always_comb begin
    iss_ready    = 1'b0;
    tc_req_ready = 1'b0;
    state_nxt    = state;
    beat_nxt     = beat_cnt;
    case (state)
      IDLE: begin
        iss_ready    = iss_space & ~(tc_req_valid & wait_full);
        tc_req_ready = tc_req_valid & (wait_full | ~(iss_valid & iss_space));
        if (tc_req_ready) begin
          state_nxt = TC_GRANT;
          beat_nxt  = BEAT_W'(1);
        end
      end
      TC_GRANT: begin
        iss_ready    = iss_space & ~tc_req_valid;
        tc_req_ready = tc_req_valid;
        if (tc_req_valid) begin
          if (beat_cnt >= BEAT_LAST) begin
            beat_nxt = '0;
            if (iss_valid) state_nxt = COOLDOWN;
          end else begin
            beat_nxt = beat_cnt + BEAT_W'(1);
          end
        end else begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end
      COOLDOWN: begin
        iss_ready = iss_space;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (tc_grant | ~tc_req_valid) wait_nxt = '0;
    else if (!wait_full)          wait_nxt = wait_cnt + WAIT_W'(1);
  end

  assign port_sel_tc  = tc_grant;
  assign port_read_en = ~tc_grant;
  assign port_tc_addr = tc_req_addr;

  gpr_arb_rsp_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (TAGW + 1)
  ) u_rsp_pipe (
    .clk   (clk),
    .clear (reset),
    .din   ({tc_grant, tc_req_tag}),
    .dout  (rsp_word)
  );

  assign tc_rsp_valid = rsp_word[TAGW];
  assign tc_rsp_tag   = rsp_word[TAGW-1:0];

`ifdef GPR_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_tc_stall_cycles  <= '0;
      perf_iss_stall_cycles <= '0;
      perf_forced_grants    <= '0;
    end else begin
      if (tc_req_valid & ~tc_grant)
        perf_tc_stall_cycles <= perf_tc_stall_cycles + 1'b1;
      if (iss_valid & iss_space & ~iss_ready)
        perf_iss_stall_cycles <= perf_iss_stall_cycles + 1'b1;
      if (tc_grant & (state == IDLE) & wait_full)
        perf_forced_grants <= perf_forced_grants + 1'b1;
    end
  end
`endif

  a_one_owner: assert property (@(posedge clk) disable iff (reset) !(iss_fire && tc_grant));

endmodule
